// File: rtl/dcache_refill_engine.sv
// L1 dCache miss service: optional dirty-victim writeback burst, then a
// read burst that reassembles the missing block and returns it.
module dcache_refill_engine #(
  parameter int BLOCK_BITS = 256,
  parameter int BEAT_BITS  = 32,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic [ADDR_W-1:0]     miss_addr,
  input  logic                  evict_dirty,
  input  logic [ADDR_W-1:0]     evict_addr,
  input  logic [BLOCK_BITS-1:0] evict_data,
  output logic                  busy,
  output logic                  repair_resolved,
  output logic [ADDR_W-1:0]     refill_addr,
  output logic [BLOCK_BITS-1:0] refill_data,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_we,
  output logic [ADDR_W-1:0]     mem_cmd_addr,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  output logic [BEAT_BITS-1:0]  mem_wdata,
  output logic                  mem_wlast,
  input  logic                  mem_rvalid,
  input  logic [BEAT_BITS-1:0]  mem_rdata
);

  localparam int BEATS = BLOCK_BITS / BEAT_BITS;
  localparam int OFF   = $clog2(BLOCK_BITS / 8);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WB_CMD  = 3'd1;
  localparam logic [2:0] WB_DATA = 3'd2;
  localparam logic [2:0] RD_CMD  = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] RESOLVE = 3'd5;

  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic                  beat_last;
  logic                  cmd_hs;
  logic                  w_hs;
  logic [ADDR_W-1:0]     miss_q;
  logic [ADDR_W-1:0]     cmd_addr_q;
  logic [BLOCK_BITS-1:0] evict_q;
  logic [BLOCK_BITS-1:0] rbuf;
  logic [BLOCK_BITS-1:0] rbuf_nxt;
  logic [BEAT_BITS-1:0]  wbeat;

  function automatic logic [ADDR_W-1:0] blk(
    input logic [ADDR_W-1:0] a
  );
    return {a[ADDR_W-1:OFF], {OFF{1'b0}}};
  endfunction

  assign busy            = (state != IDLE);
  assign repair_resolved = (state == RESOLVE);
  assign mem_cmd_valid   = (state == WB_CMD) |
                           (state == RD_CMD);
  assign mem_cmd_we      = (state == WB_CMD);
  assign mem_cmd_addr    = cmd_addr_q;
  assign mem_wvalid      = (state == WB_DATA);

  assign beat_last = (cnt == LAST);
  assign cnt_nxt   = beat_last ? '0 : cnt + 1'b1;
  assign cmd_hs    = mem_cmd_valid & mem_cmd_ready;
  assign w_hs      = mem_wvalid & mem_wready;
  assign mem_wlast = mem_wvalid & beat_last;
  assign mem_wdata = mem_wvalid ? wbeat : '0;

  always_comb begin
    wbeat    = '0;
    rbuf_nxt = rbuf;
    for (int i = 0; i < BEATS; i++) begin
      if (cnt == CW'(i)) begin
        wbeat = evict_q[i*BEAT_BITS +: BEAT_BITS];
        rbuf_nxt[i*BEAT_BITS +: BEAT_BITS] = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      miss_q      <= '0;
      cmd_addr_q  <= '0;
      evict_q     <= '0;
      rbuf        <= '0;
      refill_addr <= '0;
      refill_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss_req) begin
            miss_q     <= miss_addr;
            evict_q    <= evict_data;
            cmd_addr_q <= evict_dirty ? blk(evict_addr)
                                      : blk(miss_addr);
            state      <= evict_dirty ? WB_CMD : RD_CMD;
          end
        end
        WB_CMD: begin
          if (cmd_hs) state <= WB_DATA;
        end
        WB_DATA: begin
          if (w_hs) begin
            cnt <= cnt_nxt;
            if (beat_last) begin
              cmd_addr_q <= blk(miss_q);
              state      <= RD_CMD;
            end
          end
        end
        RD_CMD: begin
          if (cmd_hs) state <= RD_DATA;
        end
        RD_DATA: begin
          if (mem_rvalid) begin
            rbuf <= rbuf_nxt;
            cnt  <= cnt_nxt;
            // Publish straight from the merge so the final beat lands too
            if (beat_last) begin
              refill_data <= rbuf_nxt;
              refill_addr <= blk(miss_q);
              state       <= RESOLVE;
            end
          end
        end
        RESOLVE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_refill_engine.sv
// Directed bench for dcache_refill_engine with a small burst-memory
// responder and hand-computed blocks, addresses and latencies.
module tb_dcache_refill_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         evict_dirty;
  logic [31:0]  evict_addr;
  logic [255:0] evict_data;
  logic         busy;
  logic         repair_resolved;
  logic [31:0]  refill_addr;
  logic [255:0] refill_data;
  logic         mem_cmd_valid;
  logic         mem_cmd_ready;
  logic         mem_cmd_we;
  logic [31:0]  mem_cmd_addr;
  logic         mem_wvalid;
  logic         mem_wready;
  logic [31:0]  mem_wdata;
  logic         mem_wlast;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;

  always #5 clk = ~clk;

  dcache_refill_engine dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .evict_dirty(evict_dirty), .evict_addr(evict_addr),
    .evict_data(evict_data),
    .busy(busy), .repair_resolved(repair_resolved),
    .refill_addr(refill_addr), .refill_data(refill_data),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_wdata(mem_wdata), .mem_wlast(mem_wlast),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag, logic [255:0] got,
                     logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // responder state
  int          cmd_wait = 0;
  int          cmd_cnt  = 0;
  bit          wtog     = 0;
  bit          wph      = 0;
  bit          rd_act   = 0;
  int          rd_beat  = 0;
  logic [31:0] rd_base  = '0;
  bit          stray    = 0;
  int          pulses   = 0;
  logic [32:0] cmd_log[$];
  logic [32:0] wlog[$];
  bit          pc_stall = 0;
  logic [33:0] pc_prev  = '0;
  bit          pw_stall = 0;
  logic [33:0] pw_prev  = '0;

  function automatic logic [255:0] mkblk(logic [31:0] base);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = base + 32'(i);
    return b;
  endfunction

  // one clock: drive memory side at negedge, account, advance
  task automatic step();
    bit rd_start;
    rd_start = 0;
    mem_cmd_ready = mem_cmd_valid && (cmd_cnt >= cmd_wait);
    mem_wready = wtog ? wph : 1'b1;
    wph = ~wph;
    if (rd_act) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rd_base + 32'(rd_beat);
    end else if (stray) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0000_00EE;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
    if (pc_stall)
      chk("cmd_hold",
          {mem_cmd_valid, mem_cmd_we, mem_cmd_addr}, pc_prev);
    if (pw_stall)
      chk("w_hold", {mem_wvalid, mem_wlast, mem_wdata}, pw_prev);
    pc_stall = mem_cmd_valid && !mem_cmd_ready;
    pc_prev  = {mem_cmd_valid, mem_cmd_we, mem_cmd_addr};
    pw_stall = mem_wvalid && !mem_wready;
    pw_prev  = {mem_wvalid, mem_wlast, mem_wdata};
    if (repair_resolved) pulses++;
    if (mem_cmd_valid && mem_cmd_ready) begin
      cmd_log.push_back({mem_cmd_we, mem_cmd_addr});
      cmd_cnt = 0;
      if (!mem_cmd_we) rd_start = 1;
    end else if (mem_cmd_valid) begin
      cmd_cnt++;
    end
    if (mem_wvalid && mem_wready)
      wlog.push_back({mem_wlast, mem_wdata});
    if (rd_act) begin
      rd_beat++;
      if (rd_beat == 8) rd_act = 0;
    end
    if (rd_start) begin
      rd_act  = 1;
      rd_beat = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_res(output int lat);
    lat = 1;
    while (!repair_resolved && lat < 80) begin
      step();
      lat++;
    end
    chk("res_seen", repair_resolved, 1'b1);
  endtask

  task automatic chk_wb(logic [31:0] base);
    logic [32:0] e;
    chk("wb_count", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      e = {(i == 7) ? 1'b1 : 1'b0, base + 32'(i)};
      chk("wb_beat", wlog[i], e);
    end
  endtask

  task automatic clr();
    cmd_log.delete();
    wlog.delete();
    pulses = 0;
  endtask

  task automatic start(logic [31:0] ma, logic d,
                       logic [31:0] ea, logic [255:0] ed,
                       logic [31:0] base);
    miss_req    = 1'b1;
    miss_addr   = ma;
    evict_dirty = d;
    evict_addr  = ea;
    evict_data  = ed;
    rd_base     = base;
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int k;
    rst = 1'b1;
    miss_req = 1'b0;
    miss_addr = '0;
    evict_dirty = 1'b0;
    evict_addr = '0;
    evict_data = '0;
    mem_cmd_ready = 1'b0;
    mem_wready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    step();
    step();
    chk("rst_ctl", {busy, repair_resolved, mem_cmd_valid,
                    mem_cmd_we, mem_wvalid, mem_wlast}, 6'b0);
    chk("rst_addr", {refill_addr, mem_cmd_addr, mem_wdata}, 96'b0);
    chk("rst_data", refill_data, 256'b0);
    rst = 1'b0;
    step();

    // clean miss, ready memory, latency
    clr();
    start(32'h0000_1234, 1'b0, 32'hFFFF_FFE0, '1, 32'hA0);
    miss_req = 1'b0;
    chk("t1_busy", busy, 1'b1);
    chk("t1_cmd", {mem_cmd_valid, mem_cmd_we, mem_cmd_addr},
        {1'b1, 1'b0, 32'h0000_1220});
    wait_res(lat);
    chk("t1_lat", lat, 10);
    chk("t1_data", refill_data, mkblk(32'hA0));
    chk("t1_addr", refill_addr, 32'h0000_1220);
    chk("t1_busy_res", busy, 1'b1);
    step();
    chk("t1_pulse", {repair_resolved, busy}, 2'b00);
    chk("t1_ncmd", cmd_log.size(), 1);
    chk("t1_nwb", wlog.size(), 0);

    // dirty miss
    clr();
    start(32'h0000_3004, 1'b1, 32'h0000_8040,
          mkblk(32'hD0), 32'hB0);
    miss_req = 1'b0;
    chk("t2_cmd", {mem_cmd_valid, mem_cmd_we, mem_cmd_addr},
        {1'b1, 1'b1, 32'h0000_8040});
    wait_res(lat);
    chk("t2_ncmd", cmd_log.size(), 2);
    chk("t2_cmd0", cmd_log[0], {1'b1, 32'h0000_8040});
    chk("t2_cmd1", cmd_log[1], {1'b0, 32'h0000_3000});
    chk_wb(32'hD0);
    chk("t2_data", refill_data, mkblk(32'hB0));
    chk("t2_addr", refill_addr, 32'h0000_3000);
    step();
    chk("t2_pulse", repair_resolved, 1'b0);

    // backpressure: cmd_ready after 3 cycles, wready toggling
    clr();
    cmd_wait = 3;
    wtog = 1;
    start(32'h2222_0010, 1'b1, 32'h0000_011C,
          mkblk(32'hC0), 32'h50);
    miss_req = 1'b0;
    wait_res(lat);
    chk("t3_ncmd", cmd_log.size(), 2);
    chk("t3_cmd0", cmd_log[0], {1'b1, 32'h0000_0100});
    chk("t3_cmd1", cmd_log[1], {1'b0, 32'h2222_0000});
    chk_wb(32'hC0);
    chk("t3_data", refill_data, mkblk(32'h50));
    chk("t3_addr", refill_addr, 32'h2222_0000);
    step();
    chk("t3_pulse", repair_resolved, 1'b0);
    chk("t3_npulse", pulses, 1);
    cmd_wait = 0;
    wtog = 0;

    // miss_req held while busy, stray read beats outside RD_DATA
    clr();
    stray = 1;
    step();
    start(32'h0000_601F, 1'b1, 32'h0000_7000,
          mkblk(32'hE0), 32'h60);
    wait_res(lat);
    chk("t4_ncmd", cmd_log.size(), 2);
    chk("t4_data", refill_data, mkblk(32'h60));
    chk("t4_addr", refill_addr, 32'h0000_6000);
    step();
    chk("t4_idle", busy, 1'b0);
    chk("t4_ncmd_idle", cmd_log.size(), 2);
    start(32'h0000_5678, 1'b0, 32'h0000_7000,
          mkblk(32'hE0), 32'h90);
    miss_req = 1'b0;
    stray = 0;
    chk("t4_busy2", busy, 1'b1);
    chk("t4_cmd2", {mem_cmd_valid, mem_cmd_we, mem_cmd_addr},
        {1'b1, 1'b0, 32'h0000_5660});
    wait_res(lat);
    chk("t4_data2", refill_data, mkblk(32'h90));
    chk("t4_addr2", refill_addr, 32'h0000_5660);
    step();

    // reset in RD_DATA after 4 beats
    clr();
    start(32'h0000_9A40, 1'b0, 32'h0, '0, 32'h30);
    miss_req = 1'b0;
    k = 0;
    while (!(rd_act && rd_beat == 4) && k < 40) begin
      step();
      k++;
    end
    chk("t5_reach", rd_beat, 4);
    rst = 1'b1;
    step();
    rd_act = 0;
    rd_beat = 0;
    chk("t5_ctl", {busy, repair_resolved, mem_cmd_valid,
                   mem_cmd_we, mem_wvalid, mem_wlast}, 6'b0);
    chk("t5_addr", {refill_addr, mem_cmd_addr, mem_wdata}, 96'b0);
    chk("t5_data", refill_data, 256'b0);
    rst = 1'b0;
    repeat (12) step();
    chk("t5_nopulse", pulses, 0);
    start(32'h0000_BEE0, 1'b0, 32'h0, '0, 32'h10);
    miss_req = 1'b0;
    wait_res(lat);
    chk("t5_lat", lat, 10);
    chk("t5_data2", refill_data, mkblk(32'h10));
    chk("t5_addr2", refill_addr, 32'h0000_BEE0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
